// File: rtl/hazard_pkg.sv
// Shared types for the hazard/scoreboard unit: forwarding selects and
// multi-cycle tracker states.
package hazard_pkg;

   localparam int LAT_W_DEF = 6;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mc_state_e;

endpackage

// File: rtl/mc_tracker.sv
// One-entry scoreboard for an in-flight multi-cycle (MUL/DIV) op: counts the
// latency down and flags the single write-back cycle.
module mc_tracker
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int LAT_W  = LAT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mc_startE,
   input  logic [LAT_W-1:0]  mc_lat,
   input  logic [REG_AW-1:0] RDE,
   input  logic              mc_abort,
   output mc_state_e         state,
   output logic              mc_busy,
   output logic              mc_doneW,
   output logic [REG_AW-1:0] mc_rd
);

   logic [LAT_W-1:0] cnt;

   // A start is only honoured from IDLE; abort wins over everything else.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         mc_rd <= '0;
      end else if (mc_abort) begin
         state <= IDLE;
         cnt   <= '0;
         mc_rd <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mc_startE) begin
                  mc_rd <= RDE;
                  if (mc_lat > LAT_W'(1)) begin
                     state <= BUSY;
                     cnt   <= mc_lat - LAT_W'(1);
                  end else begin
                     state <= DONE;
                     cnt   <= '0;
                  end
               end
            end
            BUSY: begin
               // <= keeps the counter from ever wrapping below zero
               if (cnt <= LAT_W'(1)) begin
                  state <= DONE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - LAT_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign mc_busy  = (state != IDLE);
   // A trap arriving in the DONE cycle must still block the RF write.
   assign mc_doneW = (state == DONE) && !mc_abort;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: M/W forwarding, multi-cycle load-use stall, MUL/DIV
// scoreboard stalls and per-stage stall/flush control.
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int LAT_W      = LAT_W_DEF,
   parameter int LOAD_STALL = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] RS1D,
   input  logic [REG_AW-1:0] RS2D,
   input  logic [REG_AW-1:0] RDD,
   input  logic              mc_opD,
   input  logic [REG_AW-1:0] RS1E,
   input  logic [REG_AW-1:0] RS2E,
   input  logic [REG_AW-1:0] RDE,
   input  logic              rd_enE,
   input  logic              mc_startE,
   input  logic [LAT_W-1:0]  mc_lat,
   input  logic [REG_AW-1:0] RDM,
   input  logic [REG_AW-1:0] RDW,
   input  logic              w_enM,
   input  logic              w_enW,
   input  logic              PC_Mux,
   input  logic              mc_abort,
   output logic [1:0]        Forward_A,
   output logic [1:0]        Forward_B,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic              mc_busy,
   output logic              mc_doneW,
   output logic [REG_AW-1:0] mc_rd
);

   localparam logic [1:0] LU_INIT = 2'(LOAD_STALL - 1);

   mc_state_e         mc_state;
   logic              busy_i;
   logic              done_i;
   logic [REG_AW-1:0] rd_i;
   logic [1:0]        lu_cnt;
   fwd_sel_e          fwd_a;
   fwd_sel_e          fwd_b;
   logic              lu_hazard;
   logic              lu_hold;
   logic              sb_hit;
   logic              struct_hit;
   logic              stall_any;

   mc_tracker #(
      .REG_AW (REG_AW),
      .LAT_W  (LAT_W)
   ) u_mc_tracker (
      .clk       (clk),
      .rst_n     (rst_n),
      .mc_startE (mc_startE),
      .mc_lat    (mc_lat),
      .RDE       (RDE),
      .mc_abort  (mc_abort),
      .state     (mc_state),
      .mc_busy   (busy_i),
      .mc_doneW  (done_i),
      .mc_rd     (rd_i)
   );

   // M is the younger producer, so it beats W; x0 is hardwired and never forwards.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (RS1E != '0 && w_enM && RDM == RS1E)      fwd_a = FWD_MEM;
      else if (RS1E != '0 && w_enW && RDW == RS1E) fwd_a = FWD_WB;
      if (RS2E != '0 && w_enM && RDM == RS2E)      fwd_b = FWD_MEM;
      else if (RS2E != '0 && w_enW && RDW == RS2E) fwd_b = FWD_WB;
   end

   assign lu_hazard  = rd_enE && (RDE != '0) && (RS1D == RDE || RS2D == RDE);
   assign lu_hold    = (lu_cnt != 2'd0);
   assign sb_hit     = (mc_state == BUSY || mc_state == DONE) && (rd_i != '0) &&
                       (RS1D == rd_i || RS2D == rd_i || RDD == rd_i);
   assign struct_hit = mc_opD && (mc_state != IDLE);
   assign stall_any  = lu_hazard || lu_hold || sb_hit || struct_hit;

   // Extra load-use bubbles beyond the first; a redirect squashes them.
   always_ff @(posedge clk) begin
      if (!rst_n)         lu_cnt <= 2'd0;
      else if (PC_Mux)    lu_cnt <= 2'd0;
      else if (lu_hazard) lu_cnt <= LU_INIT;
      else if (lu_hold)   lu_cnt <= lu_cnt - 2'd1;
   end

   assign Forward_A = rst_n ? fwd_a : FWD_RF;
   assign Forward_B = rst_n ? fwd_b : FWD_RF;
   assign StallF    = rst_n && stall_any && !PC_Mux;
   assign StallD    = rst_n && stall_any && !PC_Mux;
   assign FlushD    = rst_n && PC_Mux;
   assign FlushE    = rst_n && (stall_any || PC_Mux);
   assign mc_busy   = rst_n && busy_i;
   assign mc_doneW  = rst_n && done_i;
   assign mc_rd     = rst_n ? rd_i : '0;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios plus random traffic
// compared every cycle against a cycle-indexed behavioural model.
module tb_hazard_scoreboard_unit;

   localparam int REG_AW = 5;
   localparam int LAT_W  = 6;
   localparam int LS     = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [REG_AW-1:0] RS1D, RS2D, RDD, RS1E, RS2E, RDE, RDM, RDW;
   logic              mc_opD, rd_enE, mc_startE, w_enM, w_enW, PC_Mux, mc_abort;
   logic [LAT_W-1:0]  mc_lat;
   logic [1:0]        Forward_A, Forward_B;
   logic              StallF, StallD, FlushD, FlushE, mc_busy, mc_doneW;
   logic [REG_AW-1:0] mc_rd;

   hazard_scoreboard_unit #(
      .REG_AW     (REG_AW),
      .LAT_W      (LAT_W),
      .LOAD_STALL (LS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .RS1D      (RS1D),
      .RS2D      (RS2D),
      .RDD       (RDD),
      .mc_opD    (mc_opD),
      .RS1E      (RS1E),
      .RS2E      (RS2E),
      .RDE       (RDE),
      .rd_enE    (rd_enE),
      .mc_startE (mc_startE),
      .mc_lat    (mc_lat),
      .RDM       (RDM),
      .RDW       (RDW),
      .w_enM     (w_enM),
      .w_enW     (w_enW),
      .PC_Mux    (PC_Mux),
      .mc_abort  (mc_abort),
      .Forward_A (Forward_A),
      .Forward_B (Forward_B),
      .StallF    (StallF),
      .StallD    (StallD),
      .FlushD    (FlushD),
      .FlushE    (FlushE),
      .mc_busy   (mc_busy),
      .mc_doneW  (mc_doneW),
      .mc_rd     (mc_rd)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // Model: an op started in cycle c with latency L completes in cycle c+L;
   // a load-use hazard in cycle c keeps D stalled through cycle c+LS-1.
   int                cyc        = 0;
   bit                m_active   = 1'b0;
   int                m_done_cyc = 0;
   logic [REG_AW-1:0] m_rd       = '0;
   int                lu_last    = -1;
   logic [REG_AW-1:0] exp_q[$];

   function automatic logic [1:0] fwd(input logic [REG_AW-1:0] rs);
      if (rs == 0)                  return 2'b00;
      if (w_enM && RDM == rs)       return 2'b10;
      if (w_enW && RDW == rs)       return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit load_hazard();
      return rd_enE && RDE != 0 && (RS1D == RDE || RS2D == RDE);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_rd     <= '0;
         lu_last  <= -1;
      end else begin
         if (PC_Mux)             lu_last <= -1;
         else if (load_hazard()) lu_last <= cyc + LS - 1;
         if (mc_abort) begin
            m_active <= 1'b0;
            m_rd     <= '0;
         end else if (m_active && cyc == m_done_cyc) begin
            m_active <= 1'b0;
         end else if (!m_active && mc_startE) begin
            m_active   <= 1'b1;
            m_rd       <= RDE;
            m_done_cyc <= cyc + ((mc_lat == 0) ? 1 : int'(mc_lat));
         end
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      bit                e_done, e_stall;
      logic [REG_AW-1:0] q_rd;
      if (!rst_n) begin
         chk("m_rst_fwd", {Forward_A, Forward_B}, 4'h0);
         chk("m_rst_ctl", {StallF, StallD, FlushD, FlushE, mc_busy, mc_doneW}, 6'h0);
         chk("m_rst_rd", mc_rd, 0);
      end else begin
         e_done  = m_active && cyc == m_done_cyc && !mc_abort;
         e_stall = load_hazard() || cyc <= lu_last ||
                   (m_active && m_rd != 0 && (RS1D == m_rd || RS2D == m_rd || RDD == m_rd)) ||
                   (mc_opD && m_active);
         chk("m_fwd_a", Forward_A, fwd(RS1E));
         chk("m_fwd_b", Forward_B, fwd(RS2E));
         chk("m_stallf", StallF, e_stall && !PC_Mux);
         chk("m_stalld", StallD, e_stall && !PC_Mux);
         chk("m_flushd", FlushD, PC_Mux);
         chk("m_flushe", FlushE, e_stall || PC_Mux);
         chk("m_busy", mc_busy, m_active);
         chk("m_donew", mc_doneW, e_done);
         chk("m_rd", mc_rd, m_rd);
         if (e_done) exp_q.push_back(m_rd);
         if (mc_doneW) begin
            if (exp_q.size() == 0) begin
               chk("sb_spurious_done", 1, 0);
            end else begin
               q_rd = exp_q.pop_front();
               chk("sb_done_rd", mc_rd, q_rd);
            end
         end
      end
   end

   task automatic set_idle();
      rst_n = 1'b1; RS1D = '0; RS2D = '0; RDD = '0; mc_opD = 1'b0;
      RS1E = '0; RS2E = '0; RDE = '0; rd_enE = 1'b0; mc_startE = 1'b0;
      mc_lat = '0; RDM = '0; RDW = '0; w_enM = 1'b0; w_enW = 1'b0;
      PC_Mux = 1'b0; mc_abort = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input int lat, input int rd);
      mc_startE = 1'b1; mc_lat = LAT_W'(lat); RDE = REG_AW'(rd);
      step();
      mc_startE = 1'b0; RDE = '0;
   endtask

   initial begin
      set_idle();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_busy", mc_busy, 0);
      chk("rst_stall", StallD, 0);
      step();
      step();
      rst_n = 1'b1;

      // forwarding priority and x0
      RS1E = 5; RS2E = 5; RDM = 5; w_enM = 1; RDW = 5; w_enW = 1;
      @(negedge clk);
      chk("fwd_a_mem", Forward_A, 2'b10);
      chk("fwd_b_mem", Forward_B, 2'b10);
      step();
      RS1E = 0; w_enM = 0;
      @(negedge clk);
      chk("fwd_a_x0", Forward_A, 2'b00);
      chk("fwd_b_wb", Forward_B, 2'b01);
      step();
      set_idle();

      // load-use with two bubbles
      rd_enE = 1; RDE = 7; RS2D = 7;
      @(negedge clk);
      chk("lu_stall0", StallD, 1);
      chk("lu_flushe0", FlushE, 1);
      step();
      rd_enE = 0;
      @(negedge clk);
      chk("lu_stall1", StallD, 1);
      chk("lu_flushe1", FlushE, 1);
      step();
      @(negedge clk);
      chk("lu_release", StallD, 0);
      step();
      set_idle();

      // RAW on an in-flight 4-cycle op
      start_op(4, 9);
      RS1D = 9;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("raw_stall", StallD, 1);
         chk("raw_done", mc_doneW, (i == 4));
         chk("raw_rd", mc_rd, 9);
         step();
      end
      @(negedge clk);
      chk("raw_release", StallD, 0);
      chk("raw_idle", mc_busy, 0);
      step();
      set_idle();

      // WAW then structural stall
      start_op(4, 9);
      RDD = 9;
      @(negedge clk);
      chk("waw_stall", StallD, 1);
      step();
      RDD = 1; mc_opD = 1; RS1D = 1; RS2D = 2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("struct_stall", StallD, 1);
         step();
      end
      @(negedge clk);
      chk("struct_release", StallD, 0);
      step();
      set_idle();

      // abort with cnt=2
      start_op(4, 9);
      RS1D = 9;
      step();
      mc_abort = 1;
      @(negedge clk);
      chk("abort_cyc_busy", mc_busy, 1);
      chk("abort_cyc_done", mc_doneW, 0);
      step();
      mc_abort = 0;
      @(negedge clk);
      chk("abort_idle", mc_busy, 0);
      chk("abort_stall", StallD, 0);
      chk("abort_rd", mc_rd, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         chk("abort_no_done", mc_doneW, 0);
      end
      step();
      set_idle();

      // abort in DONE, then latency 0 behaving as 1
      start_op(0, 3);
      mc_abort = 1;
      @(negedge clk);
      chk("abort_done_supp", mc_doneW, 0);
      step();
      mc_abort = 0;
      start_op(0, 3);
      @(negedge clk);
      chk("lat0_done", mc_doneW, 1);
      step();
      set_idle();

      // redirect over a load-use hazard
      rd_enE = 1; RDE = 7; RS1D = 7; PC_Mux = 1;
      @(negedge clk);
      chk("redir_flushd", FlushD, 1);
      chk("redir_flushe", FlushE, 1);
      chk("redir_stallf", StallF, 0);
      chk("redir_stalld", StallD, 0);
      step();
      set_idle();
      @(negedge clk);
      chk("redir_lu_clear", StallD, 0);
      step();

      // reset in BUSY
      start_op(5, 9);
      RS1D = 9; rst_n = 0;
      @(negedge clk);
      chk("rstb_busy", mc_busy, 0);
      chk("rstb_stall", StallD, 0);
      chk("rstb_flushe", FlushE, 0);
      chk("rstb_rd", mc_rd, 0);
      step();
      rst_n = 1;
      @(negedge clk);
      chk("rstb_idle", mc_busy, 0);
      chk("rstb_release", StallD, 0);
      step();
      set_idle();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         rst_n     = ($urandom_range(0, 99) != 0);
         RS1D      = REG_AW'($urandom_range(0, 3));
         RS2D      = REG_AW'($urandom_range(0, 3));
         RDD       = REG_AW'($urandom_range(0, 3));
         RS1E      = REG_AW'($urandom_range(0, 3));
         RS2E      = REG_AW'($urandom_range(0, 3));
         RDE       = REG_AW'($urandom_range(0, 3));
         RDM       = REG_AW'($urandom_range(0, 3));
         RDW       = REG_AW'($urandom_range(0, 3));
         w_enM     = $urandom_range(0, 1);
         w_enW     = $urandom_range(0, 1);
         mc_opD    = ($urandom_range(0, 3) == 0);
         rd_enE    = ($urandom_range(0, 3) == 0);
         mc_startE = ($urandom_range(0, 3) == 0);
         mc_lat    = LAT_W'($urandom_range(0, 6));
         PC_Mux    = ($urandom_range(0, 15) == 0);
         mc_abort  = ($urandom_range(0, 31) == 0);
         step();
      end
      set_idle();
      for (int n = 0; n < 10; n++) step();

      @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised successor to the pipeline data hazard unit for the RV32I core. It keeps the M/W operand forwarding and load-use detection, and adds three things: a configurable multi-cycle load-use stall, a one-entry scoreboard tracking an in-flight multi-cycle (MUL/DIV) operation, and separate stall/flush controls per stage. It sits beside the 5-stage pipeline registers and drives their enables and clears.

## Interface
Parameters:
- REG_AW, 5, register-address width
- LAT_W, 6, width of multi-cycle latency field/counter
- LOAD_STALL, 1, bubbles inserted per load-use hazard (1..3)

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- RS1D, RS2D, RDD  in  REG_AW  decode-stage sources and destination
- mc_opD  in  1  decode holds a multi-cycle op
- RS1E, RS2E, RDE  in  REG_AW  execute-stage sources and destination
- rd_enE  in  1  execute holds a load
- mc_startE  in  1  multi-cycle op issues from E this cycle
- mc_lat  in  LAT_W  cycles until result, ≥1, sampled with mc_startE
- RDM, RDW  in  REG_AW; w_enM, w_enW  in  1  mem/write-back destinations and enables
- PC_Mux  in  1  control-flow redirect resolved in E
- mc_abort  in  1  trap; kills the in-flight multi-cycle op
- Forward_A, Forward_B  out  2  operand select: 00 RF, 01 W, 10 M
- StallF, StallD  out  1  hold PC / IF-ID register
- FlushD, FlushE  out  1  clear IF-ID / ID-EX register
- mc_busy  out  1  state ≠ IDLE
- mc_doneW  out  1  multi-cycle result writes the register file this cycle
- mc_rd  out  REG_AW  destination of the tracked op

## Operation
- **Forwarding** (combinational): M has priority over W. A source equal to x0 never forwards. Forward_B mirrors Forward_A.
- **Load-use:** hazard = rd_enE && RDE≠0 && (RS1D==RDE || RS2D==RDE).
  - On a hazard: StallF=StallD=FlushE=1, and lu_cnt loads LOAD_STALL−1.
  - While lu_cnt≠0: stall and FlushE stay asserted, and lu_cnt decrements.
- **Multi-cycle tracker FSM**, states IDLE, BUSY, DONE:
  - IDLE → BUSY on mc_startE with mc_lat>1. Latch mc_rd=RDE and cnt=mc_lat−1.
  - IDLE → DONE on mc_startE with mc_lat==1.
  - BUSY: cnt decrements; when cnt==1, go to DONE.
  - DONE: mc_doneW=1 for exactly one cycle, then IDLE.
  - mc_abort in any state → IDLE, mc_rd=0, no mc_doneW. A mc_startE in the same cycle as mc_abort is ignored.
- **Scoreboard stalls:** while state ∈ {BUSY, DONE} and mc_rd≠0, stall D (StallF=StallD=1, FlushE=1) if any of these hold:
  - RS1D==mc_rd (RAW)
  - RS2D==mc_rd (RAW)
  - RDD==mc_rd (WAW)
- **Structural stall:** mc_opD while state≠IDLE stalls D the same way.
- **Redirect:** PC_Mux forces FlushD=FlushE=1 and StallF=StallD=0, and clears lu_cnt. Redirect overrides every stall source. The tracker is not affected by PC_Mux.
- All stall sources are OR-ed together. FlushE is asserted whenever StallD is.

## Timing
- **Reset:** while rst_n=0 at a clock edge, the FSM goes to IDLE and cnt, lu_cnt and mc_rd go to 0. All outputs read 0 during reset.
- **Latency:**
  - Forward and stall outputs are combinational from inputs plus registered state, in the same cycle.
  - mc_doneW asserts mc_lat cycles after the mc_startE edge.
  - A dependent instruction leaves D the cycle after DONE, when the RF already holds the result.
- **Boundaries:**
  - mc_lat=0 is treated as 1.
  - cnt never wraps.
  - mc_abort during DONE suppresses mc_doneW.
  - Load-use hazard and scoreboard stall coincident: one combined stall, lu_cnt still loads.
  - Reset mid-BUSY discards the op.

## Structure
- hazard_pkg holds:
  - fwd_sel_e (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10)
  - mc_state_e (IDLE, BUSY, DONE)
  - a LAT_W default constant
- One sub-module, mc_tracker: the FSM, counter and mc_rd register, with outputs mc_busy, mc_doneW, mc_rd.
- Forwarding, load-use and stall merging stay in the top level.

## Test plan
- RS1E=5, RDM=5, w_enM=1, RDW=5, w_enW=1 → Forward_A=10. Same with RS1E=0 → Forward_A=00.
- LOAD_STALL=2; rd_enE=1, RDE=7, RS2D=7 → StallD and FlushE high for exactly 2 cycles, then low.
- mc_startE with mc_lat=4, RDE=9, then RS1D=9 held in D → stall for 4 cycles, mc_doneW on cycle 4, release the next cycle.
- mc_lat=4 in flight, mc_opD=1 with unrelated regs → structural stall until IDLE. RDD=9 → WAW stall.
- BUSY with cnt=2, mc_abort=1 → IDLE next cycle, no mc_doneW, stall drops.
- PC_Mux=1 during a load-use hazard → FlushD=FlushE=1, StallF=StallD=0, lu_cnt=0. rst_n=0 in BUSY → all outputs 0, IDLE.
